// File: rtl/clf_head_scheduler.sv
// Classification head: global average pool over N patches, then per-class dot product plus bias
// on one shared MAC, streaming saturated Q1.15 logits and reporting the argmax class.
module clf_head_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int E           = 64,
    parameter int N           = 16,
    parameter int NUM_CLASSES = 10
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 start,
    output logic                                                 busy,
    output logic                                                 done,
    output logic                                                 emb_rd_en,
    output logic [$clog2(N*E)-1:0]                               emb_rd_addr,
    input  logic [DATA_WIDTH-1:0]                                emb_rd_data,
    output logic                                                 w_rd_en,
    output logic [$clog2(E*NUM_CLASSES)-1:0]                     w_rd_addr,
    input  logic [DATA_WIDTH-1:0]                                w_rd_data,
    input  logic [DATA_WIDTH*NUM_CLASSES-1:0]                    b_clf_in,
    output logic                                                 logit_valid,
    input  logic                                                 logit_ready,
    output logic [DATA_WIDTH-1:0]                                logit_data,
    output logic [((NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1)-1:0] logit_idx,
    output logic [((NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1)-1:0] class_idx
);
    localparam int DW  = DATA_WIDTH;
    localparam int LN  = $clog2(N);
    localparam int SW  = DW + LN;
    localparam int AW  = 2 * DW + $clog2(E);
    localparam int IW  = (E > 1) ? $clog2(E) : 1;
    localparam int CW  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int EAW = $clog2(N * E);
    localparam int WAW = $clog2(E * NUM_CLASSES);

    localparam logic signed [AW-1:0] SAT_HI = {{(AW-2*DW+2){1'b0}}, {(2*DW-2){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-2*DW+2){1'b1}}, {(2*DW-2){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_POOL, S_POOL_DRAIN, S_SCALE, S_MAC, S_MAC_DRAIN, S_FINAL, S_EMIT, S_DONE
    } state_t;

    state_t                 state_q;
    logic                   busy_q, done_q;
    logic                   emb_rd_en_q, w_rd_en_q;
    logic [EAW-1:0]         emb_rd_addr_q;
    logic [WAW-1:0]         w_rd_addr_q;
    logic                   emb_vld_q, w_vld_q;
    logic [IW-1:0]          i_q, idx_dly_q;
    logic [CW-1:0]          c_q, max_idx_q, class_idx_q, logit_idx_q;
    logic                   logit_valid_q;
    logic [DW-1:0]          logit_data_q;
    logic signed [DW-1:0]   max_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [SW-1:0]   sum_q  [E];
    logic signed [DW-1:0]   mean_q [E];

    logic signed [DW-1:0]   mean_d [E];
    logic signed [2*DW-1:0] prod_d;
    logic signed [DW-1:0]   bias_d;
    logic signed [AW-1:0]   acc_fin_d;
    logic [DW-1:0]          logit_d;

    // Division by N rounds toward zero: bias negative sums by N-1 before the arithmetic shift.
    genvar gi;
    generate
        for (gi = 0; gi < E; gi++) begin : g_mean
            logic signed [SW-1:0] biased;
            assign biased      = sum_q[gi] + (sum_q[gi][SW-1] ? SW'(N - 1) : SW'(0));
            assign mean_d[gi]  = DW'(biased >>> LN);
        end
    endgenerate

    assign prod_d    = mean_q[idx_dly_q] * $signed(w_rd_data);
    assign bias_d    = b_clf_in[int'(c_q)*DW +: DW];
    assign acc_fin_d = acc_q + ({{(AW-DW){bias_d[DW-1]}}, bias_d} <<< (DW - 1));

    always_comb begin
        logit_d = acc_fin_d[2*DW-2:DW-1];
        if (acc_fin_d > SAT_HI) begin
            logit_d = {1'b0, {(DW-1){1'b1}}};
        end else if (acc_fin_d < SAT_LO) begin
            logit_d = {1'b1, {(DW-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            emb_rd_en_q   <= 1'b0;
            w_rd_en_q     <= 1'b0;
            emb_rd_addr_q <= '0;
            w_rd_addr_q   <= '0;
            emb_vld_q     <= 1'b0;
            w_vld_q       <= 1'b0;
            i_q           <= '0;
            idx_dly_q     <= '0;
            c_q           <= '0;
            max_idx_q     <= '0;
            class_idx_q   <= '0;
            logit_idx_q   <= '0;
            logit_valid_q <= 1'b0;
            logit_data_q  <= '0;
            max_q         <= '0;
            acc_q         <= '0;
            for (int k = 0; k < E; k++) begin
                sum_q[k]  <= '0;
                mean_q[k] <= '0;
            end
        end else begin
            // Read data lands one cycle after its strobe; accumulate with the delayed element index.
            emb_vld_q <= emb_rd_en_q;
            w_vld_q   <= w_rd_en_q;
            idx_dly_q <= i_q;
            done_q    <= 1'b0;
            if (emb_vld_q) begin
                sum_q[idx_dly_q] <= sum_q[idx_dly_q] + {{LN{emb_rd_data[DW-1]}}, emb_rd_data};
            end
            if (w_vld_q) begin
                acc_q <= acc_q + {{(AW-2*DW){prod_d[2*DW-1]}}, prod_d};
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q       <= S_POOL;
                        busy_q        <= 1'b1;
                        emb_rd_en_q   <= 1'b1;
                        emb_rd_addr_q <= '0;
                        i_q           <= '0;
                        for (int k = 0; k < E; k++) sum_q[k] <= '0;
                    end
                end
                S_POOL: begin
                    i_q <= (i_q == IW'(E - 1)) ? '0 : i_q + 1'b1;
                    if (emb_rd_addr_q == EAW'(N * E - 1)) begin
                        emb_rd_en_q <= 1'b0;
                        state_q     <= S_POOL_DRAIN;
                    end else begin
                        emb_rd_addr_q <= emb_rd_addr_q + 1'b1;
                    end
                end
                S_POOL_DRAIN: state_q <= S_SCALE;
                S_SCALE: begin
                    for (int k = 0; k < E; k++) mean_q[k] <= mean_d[k];
                    state_q     <= S_MAC;
                    acc_q       <= '0;
                    w_rd_en_q   <= 1'b1;
                    w_rd_addr_q <= '0;
                    i_q         <= '0;
                    c_q         <= '0;
                end
                S_MAC: begin
                    if (i_q == IW'(E - 1)) begin
                        w_rd_en_q <= 1'b0;
                        state_q   <= S_MAC_DRAIN;
                    end else begin
                        i_q         <= i_q + 1'b1;
                        w_rd_addr_q <= w_rd_addr_q + 1'b1;
                    end
                end
                S_MAC_DRAIN: state_q <= S_FINAL;
                S_FINAL: begin
                    logit_data_q  <= logit_d;
                    logit_idx_q   <= c_q;
                    logit_valid_q <= 1'b1;
                    state_q       <= S_EMIT;
                end
                S_EMIT: begin
                    if (logit_ready) begin
                        logit_valid_q <= 1'b0;
                        if (c_q == '0 || $signed(logit_data_q) > max_q) begin
                            max_q     <= logit_data_q;
                            max_idx_q <= c_q;
                        end
                        if (c_q == CW'(NUM_CLASSES - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            c_q         <= c_q + 1'b1;
                            state_q     <= S_MAC;
                            acc_q       <= '0;
                            w_rd_en_q   <= 1'b1;
                            w_rd_addr_q <= w_rd_addr_q + 1'b1;
                            i_q         <= '0;
                        end
                    end
                end
                S_DONE: begin
                    done_q      <= 1'b1;
                    class_idx_q <= max_idx_q;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign emb_rd_en   = emb_rd_en_q;
    assign emb_rd_addr = emb_rd_addr_q;
    assign w_rd_en     = w_rd_en_q;
    assign w_rd_addr   = w_rd_addr_q;
    assign logit_valid = logit_valid_q;
    assign logit_data  = logit_data_q;
    assign logit_idx   = logit_idx_q;
    assign class_idx   = class_idx_q;
endmodule
